led_pulse_scheduler: RTL and testbench
======================================

Name: led_pulse_scheduler

Overview:
- Shares one front-panel activity indicator between NUM_REQ event sources.
- Latches single-cycle event strobes as per-source pending bits.
- Grants pending sources round-robin. Each grant drives a fixed-length extended pulse followed by a fixed off-gap, so successive events stay visually distinct.
- active_id identifies the source being shown, for colour/LED multiplexing downstream.

Parameters:
- NUM_REQ, 4, number of event sources (2..16).
- PULSE_LEN, 16, pulse_out high time in clk cycles (1..2^CNT_W).
- GAP_LEN, 4, forced low time after each pulse in clk cycles (0..2^CNT_W).
- CNT_W, 8, width of the shared phase counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  permits new grants; a pulse/gap in progress always completes.
- event_in  in  NUM_REQ  per-source event strobe, sampled every cycle.
- pulse_out  out  1  extended indicator pulse, registered.
- active_id  out  ID_W=clog2(NUM_REQ)  source of the current or last pulse, registered.
- busy  out  1  high in PULSE or GAP.
- pending  out  NUM_REQ  latched, not-yet-served events.

Behaviour:
- Reset (async, reset=0): state IDLE, pulse_out=0, active_id=0, busy=0, pending=0, phase counter=0, rr_ptr=0. Reset asserted mid-pulse forces pulse_out low immediately; no resumption.
- Pending capture: at each edge, pending[i] <= pending[i] | event_in[i], except for the source granted that edge.
  - Granted source clears unless event_in[i] is high the same cycle; set wins over clear.
  - An event_in held high for k cycles sets pending repeatedly but yields one pulse per grant, not k pulses.
- Arbitration: winner = first set pending bit searching from rr_ptr upward, wrapping modulo NUM_REQ. On grant, rr_ptr <= winner+1 (wrap to 0 at NUM_REQ).
- States: IDLE, PULSE, GAP.
  - IDLE: if enable && |pending, go to PULSE at the next edge. At that edge: pulse_out<=1, active_id<=winner, counter<=0, clear pending[winner].
  - PULSE: counter increments each cycle. On its last cycle (counter==PULSE_LEN-1) the next state is GAP with pulse_out<=0 and counter<=0. If GAP_LEN==0, this last cycle is instead the arbitration cycle (below).
  - GAP: pulse_out=0, counter increments. Its last cycle (counter==GAP_LEN-1) is the arbitration cycle.
  - Arbitration cycle: if enable && |pending, re-grant straight to PULSE (no extra IDLE cycle); else go to IDLE.
- Timing:
  - Latency: event strobe in cycle t → pending visible t+1 → pulse_out high from t+2.
  - Back-to-back grants give exactly GAP_LEN low cycles between pulses.
  - GAP_LEN==0 with continuous pending: pulse_out stays high while active_id changes every PULSE_LEN cycles.
- active_id holds its value through GAP and IDLE until the next grant.
- busy is registered and equals (state != IDLE).
- enable deasserted mid-pulse: current PULSE and GAP complete, then IDLE; pending keeps accumulating. Re-enable grants on the next IDLE cycle.
- Counter never exceeds max(PULSE_LEN, GAP_LEN)-1; no wrap occurs.

Optional Feature:
- Macro LED_SCHED_OVERFLOW_EN.
- Defined: adds input ovf_clear (1) and output overflow (NUM_REQ).
  - overflow[i] sets sticky when event_in[i]=1 while pending[i] is already 1 and not being granted that cycle.
  - Synchronous ovf_clear clears all bits; a same-cycle set wins. Reset value is 0.
- Undefined: these ports and that logic are absent; coalesced events are silently merged.

Decomposition:
- Package led_sched_pkg:
  - state enum {IDLE, PULSE, GAP}.
  - default PULSE_LEN/GAP_LEN constants.
  - ID_W function (clog2).
- Sub-module rr_pick: purely combinational round-robin finder.
  - Inputs: req vector, rr_ptr.
  - Outputs: found, winner index.
- FSM, counter and pending register stay in led_pulse_scheduler.

Test Plan:
- Single event (NUM_REQ=4, PULSE_LEN=16, GAP_LEN=4), 1-cycle strobe on source 2 at cycle 10 → pulse_out high cycles 12–27, active_id=2, busy high cycles 12–31, then idle.
- Simultaneous strobes on sources 0,1,3 with rr_ptr=0 → three pulses in order 0,1,3, each separated by exactly 4 low cycles; rr_ptr ends at 0.
- Re-event during own pulse: source 1 strobes again at its grant edge and again mid-pulse → exactly one further pulse for source 1; with LED_SCHED_OVERFLOW_EN, overflow[1]=1 from the mid-pulse strobe only.
- enable=0 while events arrive on sources 0 and 2 → no pulse, pending=4'b0101. Raise enable → pulse for 0 then 2.
- GAP_LEN=0, sources 0 and 1 pending → pulse_out continuously high for 32 cycles, active_id 0 then 1 at cycle boundary 16.
- Reset asserted mid-PULSE (cycle 5 of 16) → pulse_out, busy, pending and active_id read 0 immediately. After release, a new strobe restarts with the normal 2-cycle latency.

Source files
------------

// File: rtl/led_sched_pkg.sv
// Shared types and defaults for the LED pulse scheduler.
// Holds the FSM state encoding, default timing constants and the id width helper.
package led_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } sched_state_e;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_PULSE_LEN = 16;
    localparam int DEF_GAP_LEN   = 4;
    localparam int DEF_CNT_W     = 8;

    // Width of a source index; never narrower than one bit.
    function automatic int id_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/led_pulse_scheduler_if.sv
// Event/indicator bundle between the event sources, the scheduler and the LED driver.
// With LED_SCHED_OVERFLOW_EN defined it also carries ovf_clear and overflow.
interface led_pulse_scheduler_if #(
    parameter int NUM_REQ = led_sched_pkg::DEF_NUM_REQ
);
    localparam int ID_W = led_sched_pkg::id_w(NUM_REQ);

    logic               enable;
    logic [NUM_REQ-1:0] event_in;
    logic               pulse_out;
    logic [ID_W-1:0]    active_id;
    logic               busy;
    logic [NUM_REQ-1:0] pending;
`ifdef LED_SCHED_OVERFLOW_EN
    logic               ovf_clear;
    logic [NUM_REQ-1:0] overflow;

    modport master (
        output enable, event_in, ovf_clear,
        input  pulse_out, active_id, busy, pending, overflow
    );
    modport slave (
        input  enable, event_in, ovf_clear,
        output pulse_out, active_id, busy, pending, overflow
    );
`else
    modport master (
        output enable, event_in,
        input  pulse_out, active_id, busy, pending
    );
    modport slave (
        input  enable, event_in,
        output pulse_out, active_id, busy, pending
    );
`endif

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin finder: first set request at or above ptr, wrapping.
// ptr is expected to be below N.
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           found,
    output logic [IDW-1:0] winner
);

    logic [N-1:0] rot;
    int           pos;
    int           w;

    always_comb begin
        // Rotate so that bit 0 of rot is the request at ptr.
        rot = N'({req, req} >> ptr);
        pos = 0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                pos = k;
            end
        end
        w = int'(ptr) + pos;
        if (w >= N) begin
            w = w - N;
        end
        found  = |req;
        winner = IDW'(w);
    end

endmodule

// File: rtl/led_pulse_scheduler.sv
// Shares one activity LED between NUM_REQ event sources: round-robin pulse + off-gap.
// Optional sticky overflow flags are built when LED_SCHED_OVERFLOW_EN is defined.
//
//   state | meaning
//   IDLE  | LED off, grants whenever enabled and something is pending
//   PULSE | LED on for PULSE_LEN cycles showing active_id
//   GAP   | LED forced off for GAP_LEN cycles before the next grant
module led_pulse_scheduler
    import led_sched_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int PULSE_LEN = DEF_PULSE_LEN,
    parameter int GAP_LEN   = DEF_GAP_LEN,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    led_pulse_scheduler_if.slave bus
);

    localparam int               ID_W       = id_w(NUM_REQ);
    localparam bit               HAS_GAP    = (GAP_LEN > 0);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(HAS_GAP ? GAP_LEN - 1 : 0);

    sched_state_e       state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    active_id_q, active_id_d;
    logic               pulse_q, pulse_d;
    logic               busy_q, busy_d;

    logic               found;
    logic [ID_W-1:0]    winner;
    logic               last_pulse;
    logic               last_gap;
    logic               arb_cycle;
    logic               grant;
    logic [NUM_REQ-1:0] grant_mask;

    rr_pick #(
        .N   (NUM_REQ),
        .IDW (ID_W)
    ) u_rr_pick (
        .req    (pending_q),
        .ptr    (rr_ptr_q),
        .found  (found),
        .winner (winner)
    );

    always_comb begin
        last_pulse = (state_q == PULSE) && (cnt_q == PULSE_LAST);
        last_gap   = HAS_GAP && (state_q == GAP) && (cnt_q == GAP_LAST);
        // Without a gap the final pulse cycle doubles as the arbitration cycle.
        arb_cycle  = (state_q == IDLE) || last_gap || (last_pulse && !HAS_GAP);
        grant      = arb_cycle && bus.enable && found;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_mask[i] = grant && (winner == ID_W'(i));
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = PULSE;
                    cnt_d   = '0;
                end
            end
            PULSE: begin
                if (!last_pulse) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (HAS_GAP) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else begin
                    state_d = grant ? PULSE : IDLE;
                    cnt_d   = '0;
                end
            end
            GAP: begin
                if (!last_gap) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    state_d = grant ? PULSE : IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // A same-cycle event re-arms the source that is just being granted.
        pending_d   = (pending_q & ~grant_mask) | bus.event_in;
        rr_ptr_d    = rr_ptr_q;
        active_id_d = active_id_q;
        if (grant) begin
            rr_ptr_d    = (int'(winner) == NUM_REQ - 1) ? '0 : winner + ID_W'(1);
            active_id_d = winner;
        end
        pulse_d = (state_d == PULSE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pending_q   <= '0;
            rr_ptr_q    <= '0;
            active_id_q <= '0;
            pulse_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            rr_ptr_q    <= rr_ptr_d;
            active_id_q <= active_id_d;
            pulse_q     <= pulse_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.pulse_out = pulse_q;
    assign bus.active_id = active_id_q;
    assign bus.busy      = busy_q;
    assign bus.pending   = pending_q;

`ifdef LED_SCHED_OVERFLOW_EN
    logic [NUM_REQ-1:0] overflow_q, overflow_d;

    always_comb begin
        // A fresh coalesced event wins over a same-cycle clear.
        overflow_d = bus.ovf_clear ? '0 : overflow_q;
        overflow_d = overflow_d | (bus.event_in & pending_q & ~grant_mask);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_q <= '0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign bus.overflow = overflow_q;
`endif

endmodule

// File: tb/tb_led_pulse_scheduler.sv
// Bench for led_pulse_scheduler: a GAP_LEN=4 and a GAP_LEN=0 instance driven in lockstep
// and compared each cycle against a phase/time-left model, plus directed timing scenarios.
module tb_led_pulse_scheduler;
    import led_sched_pkg::*;

    localparam int N      = 4;
    localparam int PLEN   = 16;
    localparam int GLEN_A = 4;
    localparam int GLEN_B = 0;

    // mode: 0 = dark/idle, 1 = lit, 2 = forced dark; left = cycles remaining in mode
    typedef struct packed {
        int           mode;
        int           left;
        int           id;
        int           ptr;
        logic [N-1:0] pend;
        logic [N-1:0] ovf;
    } model_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    led_pulse_scheduler_if #(.NUM_REQ(N)) bus_a ();
    led_pulse_scheduler_if #(.NUM_REQ(N)) bus_b ();

    led_pulse_scheduler #(
        .NUM_REQ(N), .PULSE_LEN(PLEN), .GAP_LEN(GLEN_A), .CNT_W(8)
    ) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );

    led_pulse_scheduler #(
        .NUM_REQ(N), .PULSE_LEN(PLEN), .GAP_LEN(GLEN_B), .CNT_W(8)
    ) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

    int     n_chk = 0;
    int     n_err = 0;
    model_t ma, mb;

    int   ids_a[$], gaps_a[$], ids_b[$], runs_b[$];
    logic prev_a, seen_a, prev_b;
    int   low_a, hi_b;
    logic [1:0] prev_id_b;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic is_set(input logic [N-1:0] v, input int idx);
        return ((v >> idx) & N'(1)) != '0;
    endfunction

    function automatic model_t step(input model_t m, input logic en, input logic [N-1:0] ev,
                                    input logic clr, input int glen);
        model_t n;
        int     w;
        logic   may_grant;
        n = m;
        w = -1;
        may_grant = 1'b0;
        if (m.mode == 0) may_grant = 1'b1;
        else if (m.left > 1) n.left = m.left - 1;
        else if (m.mode == 1 && glen > 0) begin
            n.mode = 2;
            n.left = glen;
        end else may_grant = 1'b1;
        if (may_grant) begin
            n.mode = 0;
            if (en) begin
                for (int k = 0; k < N; k++) begin
                    if (w < 0 && is_set(m.pend, (m.ptr + k) % N)) w = (m.ptr + k) % N;
                end
            end
            if (w >= 0) begin
                n.mode = 1;
                n.left = PLEN;
                n.id   = w;
                n.ptr  = (w + 1) % N;
            end
        end
        n.pend = m.pend;
        if (w >= 0) n.pend = n.pend & ~(N'(1) << w);
        n.pend = n.pend | ev;
        n.ovf  = clr ? '0 : m.ovf;
        for (int i = 0; i < N; i++) begin
            if (is_set(ev, i) && is_set(m.pend, i) && i != w) n.ovf = n.ovf | (N'(1) << i);
        end
        return n;
    endfunction

    function automatic int qcode(input int q[$]);
        int c;
        c = 0;
        foreach (q[i]) c = (c << 4) | (q[i] & 15);
        return (q.size() << 24) | c;
    endfunction

    task automatic drive(input logic en, input logic [N-1:0] ev, input logic clr);
        bus_a.enable   = en;
        bus_b.enable   = en;
        bus_a.event_in = ev;
        bus_b.event_in = ev;
`ifdef LED_SCHED_OVERFLOW_EN
        bus_a.ovf_clear = clr;
        bus_b.ovf_clear = clr;
`endif
    endtask

    task automatic check_all();
        check_eq("a_pulse", 32'(bus_a.pulse_out), 32'(ma.mode == 1));
        check_eq("a_busy",  32'(bus_a.busy),      32'(ma.mode != 0));
        check_eq("a_id",    32'(bus_a.active_id), 32'(ma.id));
        check_eq("a_pend",  32'(bus_a.pending),   32'(ma.pend));
        check_eq("b_pulse", 32'(bus_b.pulse_out), 32'(mb.mode == 1));
        check_eq("b_busy",  32'(bus_b.busy),      32'(mb.mode != 0));
        check_eq("b_id",    32'(bus_b.active_id), 32'(mb.id));
        check_eq("b_pend",  32'(bus_b.pending),   32'(mb.pend));
`ifdef LED_SCHED_OVERFLOW_EN
        check_eq("a_ovf",   32'(bus_a.overflow),  32'(ma.ovf));
        check_eq("b_ovf",   32'(bus_b.overflow),  32'(mb.ovf));
`endif
    endtask

    task automatic clear_mon();
        ids_a.delete(); gaps_a.delete(); ids_b.delete(); runs_b.delete();
        prev_a = 1'b0; seen_a = 1'b0; prev_b = 1'b0; low_a = 0; hi_b = 0; prev_id_b = '0;
    endtask

    task automatic monitor();
        if (bus_a.pulse_out && !prev_a) begin
            ids_a.push_back(int'(bus_a.active_id));
            if (seen_a) gaps_a.push_back(low_a);
            seen_a = 1'b1;
            low_a  = 0;
        end
        if (!bus_a.pulse_out && seen_a) low_a++;
        prev_a = bus_a.pulse_out;
        if (bus_b.pulse_out && (!prev_b || bus_b.active_id != prev_id_b))
            ids_b.push_back(int'(bus_b.active_id));
        if (bus_b.pulse_out) hi_b++;
        else if (prev_b) begin
            runs_b.push_back(hi_b);
            hi_b = 0;
        end
        prev_b    = bus_b.pulse_out;
        prev_id_b = bus_b.active_id;
    endtask

    task automatic tick(input logic en, input logic [N-1:0] ev, input logic clr);
        drive(en, ev, clr);
        @(posedge clk);
        ma = step(ma, en, ev, clr, GLEN_A);
        mb = step(mb, en, ev, clr, GLEN_B);
        #1;
        check_all();
        monitor();
    endtask

    task automatic do_reset();
        drive(1'b0, '0, 1'b0);
        reset = 1'b0;
        #2;
        ma = '0;
        mb = '0;
        check_all();
        clear_mon();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_idle(input int max_cycles);
        int n;
        n = 0;
        while ((bus_a.busy || bus_b.busy || bus_a.pending != '0 || bus_b.pending != '0)
               && n < max_cycles) begin
            tick(1'b1, '0, 1'b0);
            n++;
        end
        check_eq("idle_wait", 32'(n < max_cycles), 32'd1);
    endtask

    // Strobe one source once and measure latency, lit time and gap on instance A.
    task automatic pulse_timing(input int src, input string tag);
        int n, hi, tail;
        tick(1'b1, N'(1) << src, 1'b0);
        n = 0;
        while (!bus_a.pulse_out && n < 8) begin tick(1'b1, '0, 1'b0); n++; end
        check_eq({tag, "_lat"}, 32'(n), 32'd1);
        check_eq({tag, "_id"}, 32'(bus_a.active_id), 32'(src));
        hi = 0;
        while (bus_a.pulse_out && hi < 40) begin tick(1'b1, '0, 1'b0); hi++; end
        check_eq({tag, "_hi"}, 32'(hi), 32'(PLEN));
        tail = 0;
        while (bus_a.busy && tail < 40) begin tick(1'b1, '0, 1'b0); tail++; end
        check_eq({tag, "_gap"}, 32'(tail), 32'(GLEN_A));
    endtask

    initial begin
        #100_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int b_run;
        logic [N-1:0] ev;
        #1;
        // single strobe on source 2 at cycle 10
        do_reset();
        repeat (9) tick(1'b1, '0, 1'b0);
        pulse_timing(2, "single");
        run_idle(100);

        // simultaneous strobes on 0,1,3
        do_reset();
        tick(1'b1, 4'b1011, 1'b0);
        run_idle(200);
        check_eq("rr_ids", 32'(qcode(ids_a)), 32'h0300_0013);
        check_eq("rr_gaps", 32'(qcode(gaps_a)), 32'h0200_0044);
        check_eq("b_rr_ids", 32'(qcode(ids_b)), 32'h0300_0013);
        b_run = (runs_b.size() > 0) ? runs_b[0] : -1;
        check_eq("b_rr_run", 32'(b_run), 32'(3 * PLEN));
        // pointer should be back at 0: source 0 beats source 3
        clear_mon();
        tick(1'b1, 4'b1001, 1'b0);
        run_idle(200);
        check_eq("ptr_wrap", 32'(qcode(ids_a)), 32'h0200_0003);

        // re-event of source 1 at its grant edge and mid-pulse
        do_reset();
        tick(1'b1, 4'b0010, 1'b0);
        tick(1'b1, 4'b0010, 1'b0);
`ifdef LED_SCHED_OVERFLOW_EN
        check_eq("ovf_grant", 32'(bus_a.overflow[1]), 32'd0);
`endif
        repeat (5) tick(1'b1, '0, 1'b0);
        tick(1'b1, 4'b0010, 1'b0);
`ifdef LED_SCHED_OVERFLOW_EN
        check_eq("ovf_mid", 32'(bus_a.overflow[1]), 32'd1);
`endif
        run_idle(200);
        check_eq("re_ids", 32'(qcode(ids_a)), 32'h0200_0011);

        // events held off by enable=0
        do_reset();
        tick(1'b0, 4'b0001, 1'b0);
        tick(1'b0, 4'b0000, 1'b0);
        tick(1'b0, 4'b0100, 1'b0);
        repeat (3) tick(1'b0, '0, 1'b0);
        check_eq("en_pend", 32'(bus_a.pending), 32'h5);
        check_eq("en_busy", 32'(bus_a.busy), 32'd0);
        run_idle(200);
        check_eq("en_ids", 32'(qcode(ids_a)), 32'h0200_0002);

        // two sources pending: gapless instance stays lit for two pulses
        do_reset();
        tick(1'b1, 4'b0011, 1'b0);
        run_idle(200);
        b_run = (runs_b.size() > 0) ? runs_b[0] : -1;
        check_eq("g0_run", 32'(b_run), 32'(2 * PLEN));
        check_eq("g0_ids", 32'(qcode(ids_b)), 32'h0200_0001);
        check_eq("g4_gaps", 32'(qcode(gaps_a)), 32'h0100_0004);

        // reset in the middle of a pulse, then a normal restart
        do_reset();
        tick(1'b1, 4'b1100, 1'b0);
        repeat (6) tick(1'b1, '0, 1'b0);
        check_eq("pre_rst_lit", 32'(bus_a.pulse_out), 32'd1);
        do_reset();
        check_eq("rst_pend", 32'(bus_a.pending), 32'd0);
        pulse_timing(1, "post_rst");
        run_idle(100);

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            ev = '0;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 9) == 0) ev = ev | (N'(1) << i);
            end
            tick($urandom_range(0, 7) != 0, ev, $urandom_range(0, 15) == 0);
            if ($urandom_range(0, 999) == 0) do_reset();
        end
        run_idle(400);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
